ompss_acc_cmd_handler: RTL and testbench



---
 rtl/ompss_cmd_pkg.sv | 24 ++
 rtl/ompss_arg_buffer.sv | 27 ++
 rtl/ompss_acc_cmd_handler.sv | 218 +++++++++++++++++++++
 tb/tb_ompss_acc_cmd_handler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ompss_cmd_pkg.sv
// Shared command-protocol constants and FSM state type for the OmpSs
// accelerator command handler.
package ompss_cmd_pkg;

  localparam logic [7:0] CMD_EXEC_TASK   = 8'h01;
  localparam logic [7:0] CMD_FINISH_TASK = 8'h03;

  localparam int HDR_CODE_LSB  = 0;
  localparam int HDR_NARGS_LSB = 8;
  localparam int HDR_ACCID_LSB = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TID,
    ST_PID,
    ST_ARGS,
    ST_DRAIN,
    ST_RUN,
    ST_FIN0,
    ST_FIN1,
    ST_FIN2
  } state_e;

endpackage

// File: rtl/ompss_arg_buffer.sv
// Task argument register file: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module ompss_arg_buffer #(
  parameter int MAX_ARGS = 15
) (
  input  logic        clk_i,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_idx_i,
  input  logic [63:0] wr_data_i,
  input  logic [7:0]  rd_idx_i,
  output logic [63:0] rd_data_o
);

  localparam int AW = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;

  logic [63:0] mem_q [MAX_ARGS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (wr_idx_i < 8'(MAX_ARGS))) begin
      mem_q[wr_idx_i[AW-1:0]] <= wr_data_i;
    end
  end

  // Out-of-range reads return zero rather than aliasing a stored entry.
  assign rd_data_o = (rd_idx_i < 8'(MAX_ARGS)) ? mem_q[rd_idx_i[AW-1:0]] : 64'd0;

endmodule

// File: rtl/ompss_acc_cmd_handler.sv
// Accelerator-side command endpoint: parses execute-task packets, buffers
// arguments, launches the core and returns a 3-word finish packet.
module ompss_acc_cmd_handler
  import ompss_cmd_pkg::*;
#(
  parameter int ACC_ID   = 0,
  parameter int MAX_ACCS = 16,
  parameter int MAX_ARGS = 15,
  localparam int TID_W   = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cmdin_in_tvalid,
  output logic             cmdin_in_tready,
  input  logic [63:0]      cmdin_in_tdata,
  input  logic             cmdin_in_tlast,
  output logic             cmdout_out_tvalid,
  input  logic             cmdout_out_tready,
  output logic [TID_W-1:0] cmdout_out_tid,
  output logic [63:0]      cmdout_out_tdata,
  output logic             task_start,
  input  logic             task_done,
  output logic [63:0]      task_id,
  output logic [7:0]       task_nargs,
  input  logic [7:0]       arg_rd_idx,
  output logic [63:0]      arg_rd_data,
  output logic [2:0]       err_flags
);

  state_e      state_q, state_d;
  logic [7:0]  nargs_q, nargs_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] tid_q, tid_d;
  logic [63:0] pid_q, pid_d;
  logic [7:0]  task_nargs_q, task_nargs_d;
  logic [2:0]  err_q, err_d;
  logic        start_q, start_d;
  logic        drain_to_run_q, drain_to_run_d;

  logic        in_hs;
  logic        out_hs;
  logic        buf_we;
  logic [7:0]  hdr_code;
  logic [7:0]  hdr_nargs;

  assign cmdin_in_tready   = state_q inside {ST_IDLE, ST_TID, ST_PID, ST_ARGS, ST_DRAIN};
  assign cmdout_out_tvalid = state_q inside {ST_FIN0, ST_FIN1, ST_FIN2};
  assign in_hs             = cmdin_in_tvalid & cmdin_in_tready;
  assign out_hs            = cmdout_out_tvalid & cmdout_out_tready;
  assign hdr_code          = cmdin_in_tdata[HDR_CODE_LSB +: 8];
  assign hdr_nargs         = cmdin_in_tdata[HDR_NARGS_LSB +: 8];

  assign cmdout_out_tid = TID_W'(ACC_ID);
  assign task_start     = start_q;
  assign task_id        = tid_q;
  assign task_nargs     = task_nargs_q;
  assign err_flags      = err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      nargs_q        <= 8'd0;
      cnt_q          <= 8'd0;
      tid_q          <= 64'd0;
      pid_q          <= 64'd0;
      task_nargs_q   <= 8'd0;
      err_q          <= 3'b000;
      start_q        <= 1'b0;
      drain_to_run_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      nargs_q        <= nargs_d;
      cnt_q          <= cnt_d;
      tid_q          <= tid_d;
      pid_q          <= pid_d;
      task_nargs_q   <= task_nargs_d;
      err_q          <= err_d;
      start_q        <= start_d;
      drain_to_run_q <= drain_to_run_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    nargs_d          = nargs_q;
    cnt_d            = cnt_q;
    tid_d            = tid_q;
    pid_d            = pid_q;
    task_nargs_d     = task_nargs_q;
    err_d            = err_q;
    start_d          = 1'b0;
    drain_to_run_d   = drain_to_run_q;
    buf_we           = 1'b0;
    cmdout_out_tdata = 64'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          if (hdr_code == CMD_EXEC_TASK) begin
            nargs_d      = hdr_nargs;
            task_nargs_d = 8'd0;
            if (cmdin_in_tlast) begin
              err_d[2] = 1'b1;
            end else begin
              state_d = ST_TID;
            end
          end else begin
            err_d[0]       = 1'b1;
            drain_to_run_d = 1'b0;
            if (!cmdin_in_tlast) state_d = ST_DRAIN;
          end
        end
      end

      ST_TID: begin
        if (in_hs) begin
          tid_d = cmdin_in_tdata;
          if (cmdin_in_tlast) begin
            err_d[2] = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_PID;
          end
        end
      end

      ST_PID: begin
        if (in_hs) begin
          pid_d = cmdin_in_tdata;
          cnt_d = 8'd0;
          if (nargs_q == 8'd0) begin
            if (cmdin_in_tlast) begin
              state_d = ST_RUN;
              start_d = 1'b1;
            end else begin
              drain_to_run_d = 1'b1;
              state_d        = ST_DRAIN;
            end
          end else if (cmdin_in_tlast) begin
            err_d[2] = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_ARGS;
          end
        end
      end

      // Arguments past the buffer depth are consumed but dropped.
      ST_ARGS: begin
        if (in_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q < 8'(MAX_ARGS)) begin
            buf_we       = 1'b1;
            task_nargs_d = cnt_q + 8'd1;
          end else begin
            err_d[1] = 1'b1;
          end
          if (cnt_q == nargs_q - 8'd1) begin
            if (cmdin_in_tlast) begin
              state_d = ST_RUN;
              start_d = 1'b1;
            end else begin
              drain_to_run_d = 1'b1;
              state_d        = ST_DRAIN;
            end
          end else if (cmdin_in_tlast) begin
            err_d[2] = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (in_hs && cmdin_in_tlast) begin
          if (drain_to_run_q) begin
            state_d = ST_RUN;
            start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        if (task_done) state_d = ST_FIN0;
      end

      ST_FIN0: begin
        cmdout_out_tdata = {48'd0, 8'(ACC_ID), CMD_FINISH_TASK};
        if (out_hs) state_d = ST_FIN1;
      end

      ST_FIN1: begin
        cmdout_out_tdata = tid_q;
        if (out_hs) state_d = ST_FIN2;
      end

      ST_FIN2: begin
        cmdout_out_tdata = pid_q;
        if (out_hs) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  ompss_arg_buffer #(
    .MAX_ARGS (MAX_ARGS)
  ) u_arg_buffer (
    .clk_i     (aclk),
    .wr_en_i   (buf_we),
    .wr_idx_i  (cnt_q),
    .wr_data_i (cmdin_in_tdata),
    .rd_idx_i  (arg_rd_idx),
    .rd_data_o (arg_rd_data)
  );

endmodule

// File: tb/tb_ompss_acc_cmd_handler.sv
// Directed self-checking bench for ompss_acc_cmd_handler with hand-computed
// expected values (ACC_ID=0, MAX_ACCS=16, MAX_ARGS=15).
module tb_ompss_acc_cmd_handler;

  localparam int ACC_ID   = 0;
  localparam int MAX_ACCS = 16;
  localparam int MAX_ARGS = 15;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmdin_in_tvalid = 1'b0;
  logic        cmdin_in_tready;
  logic [63:0] cmdin_in_tdata = 64'd0;
  logic        cmdin_in_tlast = 1'b0;
  logic        cmdout_out_tvalid;
  logic        cmdout_out_tready = 1'b0;
  logic [3:0]  cmdout_out_tid;
  logic [63:0] cmdout_out_tdata;
  logic        task_start;
  logic        task_done = 1'b0;
  logic [63:0] task_id;
  logic [7:0]  task_nargs;
  logic [7:0]  arg_rd_idx = 8'd0;
  logic [63:0] arg_rd_data;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int sc0;

  ompss_acc_cmd_handler #(
    .ACC_ID   (ACC_ID),
    .MAX_ACCS (MAX_ACCS),
    .MAX_ARGS (MAX_ARGS)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .cmdin_in_tvalid   (cmdin_in_tvalid),
    .cmdin_in_tready   (cmdin_in_tready),
    .cmdin_in_tdata    (cmdin_in_tdata),
    .cmdin_in_tlast    (cmdin_in_tlast),
    .cmdout_out_tvalid (cmdout_out_tvalid),
    .cmdout_out_tready (cmdout_out_tready),
    .cmdout_out_tid    (cmdout_out_tid),
    .cmdout_out_tdata  (cmdout_out_tdata),
    .task_start        (task_start),
    .task_done         (task_done),
    .task_id           (task_id),
    .task_nargs        (task_nargs),
    .arg_rd_idx        (arg_rd_idx),
    .arg_rd_data       (arg_rd_data),
    .err_flags         (err_flags)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (task_start) startCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cmdin beat, wait (bounded) for acceptance, then idle the bus.
  task automatic applyStimulus(input logic [63:0] data, input logic last);
    int n;
    @(negedge aclk);
    cmdin_in_tvalid = 1'b1;
    cmdin_in_tdata  = data;
    cmdin_in_tlast  = last;
    n = 0;
    while (!cmdin_in_tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("cmdin_tready", {63'd0, cmdin_in_tready}, 64'd1);
    if (cmdin_in_tready) @(posedge aclk);
    @(negedge aclk);
    cmdin_in_tvalid = 1'b0;
    cmdin_in_tlast  = 1'b0;
  endtask

  task automatic recvWord(input string tag, input logic [63:0] exp);
    int n;
    cmdout_out_tready = 1'b1;
    n = 0;
    while (!cmdout_out_tvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    checkOutput({tag, "_valid"}, {63'd0, cmdout_out_tvalid}, 64'd1);
    checkOutput(tag, cmdout_out_tdata, exp);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic pulseDone();
    task_done = 1'b1;
    @(negedge aclk);
    task_done = 1'b0;
  endtask

  task automatic finishTask(input logic [63:0] tid, input logic [63:0] pid);
    @(negedge aclk);
    pulseDone();
    recvWord("fin_hdr", 64'h3);
    recvWord("fin_tid", tid);
    recvWord("fin_pid", pid);
    cmdout_out_tready = 1'b0;
    checkOutput("fin_end_valid", {63'd0, cmdout_out_tvalid}, 64'd0);
    checkOutput("fin_end_ready", {63'd0, cmdin_in_tready}, 64'd1);
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_tready", {63'd0, cmdin_in_tready}, 64'd1);
    checkOutput("rst_tvalid", {63'd0, cmdout_out_tvalid}, 64'd0);
    checkOutput("rst_tdata", cmdout_out_tdata, 64'd0);
    checkOutput("rst_start", {63'd0, task_start}, 64'd0);
    checkOutput("rst_task_id", task_id, 64'd0);
    checkOutput("rst_nargs", {56'd0, task_nargs}, 64'd0);
    checkOutput("rst_err", {61'd0, err_flags}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // task_done while idle is ignored
    @(negedge aclk);
    pulseDone();
    checkOutput("idle_done_ignored", {63'd0, cmdout_out_tvalid}, 64'd0);

    // Execute with two args
    sc0 = startCount;
    applyStimulus(64'h0201, 1'b0);
    applyStimulus(64'hA5, 1'b0);
    applyStimulus(64'h7, 1'b0);
    applyStimulus(64'h11, 1'b0);
    applyStimulus(64'h22, 1'b1);
    checkOutput("t1_start", {63'd0, task_start}, 64'd1);
    checkOutput("t1_task_id", task_id, 64'hA5);
    checkOutput("t1_nargs", {56'd0, task_nargs}, 64'd2);
    checkOutput("t1_run_tready", {63'd0, cmdin_in_tready}, 64'd0);
    arg_rd_idx = 8'd1;
    #1;
    checkOutput("t1_arg1", arg_rd_data, 64'h22);
    arg_rd_idx = 8'd0;
    #1;
    checkOutput("t1_arg0", arg_rd_data, 64'h11);
    @(negedge aclk);
    checkOutput("t1_start_1cyc", {63'd0, task_start}, 64'd0);
    checkOutput("t1_start_count", startCount - sc0, 64'd1);

    // Finish held off by backpressure
    cmdout_out_tready = 1'b0;
    pulseDone();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t1_hold_valid", {63'd0, cmdout_out_tvalid}, 64'd1);
      checkOutput("t1_hold_data", cmdout_out_tdata, 64'h3);
      @(negedge aclk);
    end
    checkOutput("t1_out_tid", {60'd0, cmdout_out_tid}, 64'd0);
    recvWord("t1_fin_hdr", 64'h3);
    recvWord("t1_fin_tid", 64'hA5);
    recvWord("t1_fin_pid", 64'h7);
    cmdout_out_tready = 1'b0;
    checkOutput("t1_fin_done", {63'd0, cmdout_out_tvalid}, 64'd0);
    checkOutput("t1_idle_tready", {63'd0, cmdin_in_tready}, 64'd1);

    // Unknown command is drained and flagged
    sc0 = startCount;
    applyStimulus(64'h0005, 1'b0);
    applyStimulus(64'h1, 1'b0);
    applyStimulus(64'h2, 1'b0);
    applyStimulus(64'h3, 1'b1);
    repeat (2) @(negedge aclk);
    checkOutput("unk_no_start", startCount - sc0, 64'd0);
    checkOutput("unk_err", {61'd0, err_flags}, 64'h1);
    checkOutput("unk_tready", {63'd0, cmdin_in_tready}, 64'd1);

    // Following execute processed normally
    applyStimulus(64'h0101, 1'b0);
    applyStimulus(64'hB6, 1'b0);
    applyStimulus(64'h8, 1'b0);
    applyStimulus(64'h33, 1'b1);
    checkOutput("t2_start", {63'd0, task_start}, 64'd1);
    checkOutput("t2_task_id", task_id, 64'hB6);
    checkOutput("t2_nargs", {56'd0, task_nargs}, 64'd1);
    arg_rd_idx = 8'd0;
    #1;
    checkOutput("t2_arg0", arg_rd_data, 64'h33);
    finishTask(64'hB6, 64'h8);

    // Argument overflow: 17 args into a 15-deep buffer
    sc0 = startCount;
    applyStimulus(64'h1101, 1'b0);
    applyStimulus(64'hC7, 1'b0);
    applyStimulus(64'h9, 1'b0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(64'h100 + 64'(i), (i == 16));
    end
    checkOutput("ovf_start", {63'd0, task_start}, 64'd1);
    checkOutput("ovf_nargs", {56'd0, task_nargs}, 64'd15);
    checkOutput("ovf_err", {61'd0, err_flags}, 64'h3);
    arg_rd_idx = 8'd14;
    #1;
    checkOutput("ovf_arg14", arg_rd_data, 64'h10E);
    finishTask(64'hC7, 64'h9);
    checkOutput("ovf_start_once", startCount - sc0, 64'd1);

    // Short packet: nargs=3, tlast on arg index 1
    sc0 = startCount;
    applyStimulus(64'h0301, 1'b0);
    applyStimulus(64'hE1, 1'b0);
    applyStimulus(64'hF2, 1'b0);
    applyStimulus(64'h44, 1'b0);
    applyStimulus(64'h55, 1'b1);
    repeat (2) @(negedge aclk);
    checkOutput("short_no_start", startCount - sc0, 64'd0);
    checkOutput("short_err", {61'd0, err_flags}, 64'h7);
    checkOutput("short_tready", {63'd0, cmdin_in_tready}, 64'd1);

    // nargs=0, task_done coincident with task_start, reset during FIN1
    applyStimulus(64'h0001, 1'b0);
    applyStimulus(64'hD8, 1'b0);
    applyStimulus(64'hA, 1'b1);
    checkOutput("t3_start", {63'd0, task_start}, 64'd1);
    checkOutput("t3_nargs", {56'd0, task_nargs}, 64'd0);
    checkOutput("t3_task_id", task_id, 64'hD8);
    pulseDone();
    checkOutput("t3_fin0_valid", {63'd0, cmdout_out_tvalid}, 64'd1);
    recvWord("t3_fin_hdr", 64'h3);
    cmdout_out_tready = 1'b0;
    checkOutput("t3_fin1_valid", {63'd0, cmdout_out_tvalid}, 64'd1);
    checkOutput("t3_fin1_data", cmdout_out_tdata, 64'hD8);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("arst_tvalid", {63'd0, cmdout_out_tvalid}, 64'd0);
    checkOutput("arst_tdata", cmdout_out_tdata, 64'd0);
    checkOutput("arst_err", {61'd0, err_flags}, 64'd0);
    checkOutput("arst_task_id", task_id, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("arst_tready", {63'd0, cmdin_in_tready}, 64'd1);
    checkOutput("arst_no_resume", {63'd0, cmdout_out_tvalid}, 64'd0);
    checkOutput("arst_nargs", {56'd0, task_nargs}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
